// File: rtl/queue_pkg.sv
// Shared types and helpers for the multi-port queue: lane-count arithmetic and
// default pointer/count widths.
package queue_pkg;

  localparam int unsigned MaxPorts   = 4;
  localparam int unsigned DepthDflt  = 16;
  localparam int unsigned PTR_W      = $clog2(DepthDflt);
  localparam int unsigned CNT_W      = PTR_W + 1;

  function automatic logic [2:0] popcount(input logic [MaxPorts-1:0] vec);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MaxPorts; i++) begin
      n = n + {2'b00, vec[i]};
    end
    return n;
  endfunction

  // Length of the run of 1s starting at bit 0.
  function automatic logic [2:0] prefix_ones(input logic [MaxPorts-1:0] vec);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MaxPorts; i++) begin
      run = run & vec[i];
      n   = n + {2'b00, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/queue_multi_port_if.sv
// Producer/consumer bundle of the multi-port queue; the queue sits on the slave side.
interface queue_multi_port_if #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ENQ_PORTS = 2,
  parameter int unsigned DEQ_PORTS = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                         stall;
  logic                         flush;
  logic [ENQ_PORTS-1:0]         enq_valid;
  logic [ENQ_PORTS*WIDTH-1:0]   enq_data;
  logic                         enq_ready;
  logic [DEQ_PORTS-1:0]         deq_valid;
  logic [DEQ_PORTS*WIDTH-1:0]   deq_data;
  logic [DEQ_PORTS-1:0]         deq_accept;
  logic [CntW-1:0]              count;
  logic                         overflow_err;

  modport master (
    output stall, flush, enq_valid, enq_data, deq_accept,
    input  enq_ready, deq_valid, deq_data, count, overflow_err
  );

  modport slave (
    input  stall, flush, enq_valid, enq_data, deq_accept,
    output enq_ready, deq_valid, deq_data, count, overflow_err
  );

endinterface

// File: rtl/queue_lane_compact.sv
// Packs the valid enqueue lanes into consecutive slots: slot j carries the j-th valid
// lane, so the top writes slot j at tail + j with no holes.
module queue_lane_compact
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ENQ_PORTS = 2
) (
  input  logic [ENQ_PORTS-1:0]            enq_valid_i,
  input  logic [ENQ_PORTS*WIDTH-1:0]      enq_data_i,
  output logic [ENQ_PORTS-1:0]            pk_we_o,
  output logic [ENQ_PORTS-1:0][WIDTH-1:0] pk_data_o
);

  always_comb begin
    logic [MaxPorts-1:0] below;
    pk_we_o   = '0;
    pk_data_o = '0;
    for (int k = 0; k < ENQ_PORTS; k++) begin
      below = MaxPorts'((1 << k) - 1) & MaxPorts'(enq_valid_i);
      for (int j = 0; j < ENQ_PORTS; j++) begin
        if (enq_valid_i[k] && (int'(popcount(below)) == j)) begin
          pk_we_o[j]   = 1'b1;
          pk_data_o[j] = enq_data_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/queue_multi_port.sv
// Circular FIFO with several enqueue and dequeue lanes per cycle, all-or-nothing
// bundle enqueue and a head-window peek of up to DEQ_PORTS entries.
module queue_multi_port
  import queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ENQ_PORTS = 2,
  parameter int unsigned DEQ_PORTS = 2,
  parameter string       TAG       = "Queue"
) (
  input logic              clk,
  input logic              reset,
  queue_multi_port_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0]               mem_q [DEPTH];
  logic [WIDTH-1:0]               mem_d [DEPTH];
  logic [PtrW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                count_q, count_d;
  logic                           ovf_q, ovf_d;
  logic [CntW-1:0]                n_enq, n_deq;
  logic                           enq_ready;
  logic [DEQ_PORTS-1:0]           deq_valid;
  logic [DEQ_PORTS*WIDTH-1:0]     deq_data;
  logic [ENQ_PORTS-1:0]           pk_we;
  logic [ENQ_PORTS-1:0][WIDTH-1:0] pk_data;

  queue_lane_compact #(
    .WIDTH     (WIDTH),
    .ENQ_PORTS (ENQ_PORTS)
  ) u_compact (
    .enq_valid_i (bus.enq_valid),
    .enq_data_i  (bus.enq_data),
    .pk_we_o     (pk_we),
    .pk_data_o   (pk_data)
  );

  // Readiness is judged on start-of-cycle occupancy; same-cycle dequeues do not help.
  always_comb begin
    enq_ready = (CntW'(DEPTH) - count_q) >= CntW'(ENQ_PORTS);
    deq_valid = '0;
    deq_data  = '0;
    for (int k = 0; k < DEQ_PORTS; k++) begin
      deq_valid[k] = !bus.stall && (count_q > CntW'(k));
      if (deq_valid[k]) begin
        deq_data[k*WIDTH +: WIDTH] = mem_q[head_q + PtrW'(k)];
      end
    end
    n_enq = (enq_ready && !bus.flush) ? CntW'(popcount(MaxPorts'(bus.enq_valid))) : '0;
    n_deq = CntW'(prefix_ones(MaxPorts'(bus.deq_accept & deq_valid)));
  end

  always_comb begin
    mem_d = mem_q;
    if (n_enq != '0) begin
      for (int k = 0; k < ENQ_PORTS; k++) begin
        if (pk_we[k]) begin
          mem_d[tail_q + PtrW'(k)] = pk_data[k];
        end
      end
    end
    head_d  = head_q + PtrW'(n_deq);
    tail_d  = tail_q + PtrW'(n_enq);
    count_d = count_q + n_enq - n_deq;
    ovf_d   = (|bus.enq_valid) && !enq_ready && !bus.flush;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.enq_ready    = enq_ready;
  assign bus.deq_valid    = deq_valid;
  assign bus.deq_data     = deq_data;
  assign bus.count        = count_q;
  assign bus.overflow_err = ovf_q;

`ifdef QUEUE
  always_ff @(posedge clk) begin
    $display("%s count=%0d head=%0d tail=%0d n_enq=%0d n_deq=%0d",
             TAG, count_q, head_q, tail_q, n_enq, n_deq);
  end
`endif

endmodule

// File: tb/tb_queue_multi_port.sv
// Directed bench for queue_multi_port with hand-computed expectations.
module tb_queue_multi_port;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  queue_multi_port_if #(
    .DEPTH(16), .WIDTH(32), .ENQ_PORTS(2), .DEQ_PORTS(2)
  ) bus ();

  queue_multi_port #(
    .DEPTH(16), .WIDTH(32), .ENQ_PORTS(2), .DEQ_PORTS(2), .TAG("Queue")
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic flush, input logic [1:0] ev,
                       input logic [63:0] ed, input logic [1:0] acc);
    bus.stall      = stall;
    bus.flush      = flush;
    bus.enq_valid  = ev;
    bus.enq_data   = ed;
    bus.deq_accept = acc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 64'h0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check_eq("rst_enq_ready", bus.enq_ready, 1);
    check_eq("rst_deq_valid", bus.deq_valid, 0);
    check_eq("rst_deq_data", bus.deq_data, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_ovf", bus.overflow_err, 0);
    tick();
    tick();
    reset = 1'b0;

    // Two-lane enqueue, visible next cycle.
    drive(1'b0, 1'b0, 2'b11, {32'h22, 32'h11}, 2'b00);
    tick();
    idle();
    check_eq("enq2_count", bus.count, 2);
    check_eq("enq2_valid", bus.deq_valid, 2'b11);
    check_eq("enq2_data", bus.deq_data, {32'h22, 32'h11});

    // Fill to 16: entry[j] = 0xA0 + j for j = 2..15.
    for (int i = 1; i <= 7; i++) begin
      drive(1'b0, 1'b0, 2'b11, {32'(8'hA0 + 2 * i + 1), 32'(8'hA0 + 2 * i)}, 2'b00);
      tick();
    end
    idle();
    check_eq("full_count", bus.count, 16);
    check_eq("full_ready", bus.enq_ready, 0);

    drive(1'b0, 1'b0, 2'b01, {32'h0, 32'h99}, 2'b00);
    tick();
    idle();
    check_eq("rej_count", bus.count, 16);
    check_eq("rej_ovf", bus.overflow_err, 1);
    tick();
    check_eq("rej_ovf_clear", bus.overflow_err, 0);
    check_eq("rej_count2", bus.count, 16);

    // Full dequeue does not unblock the same-cycle enqueue.
    drive(1'b0, 1'b0, 2'b01, {32'h0, 32'h98}, 2'b11);
    #1;
    check_eq("full_deq_ready", bus.enq_ready, 0);
    check_eq("full_deq_data", bus.deq_data, {32'h22, 32'h11});
    tick();
    idle();
    check_eq("full_deq_count", bus.count, 14);
    check_eq("full_deq_ovf", bus.overflow_err, 1);
    check_eq("full_deq_head", bus.deq_data, {32'hA3, 32'hA2});

    // Drain to head = 14, then wrap head to 15 while enqueueing at entry[0].
    drive(1'b0, 1'b0, 2'b00, 64'h0, 2'b11);
    for (int i = 0; i < 6; i++) tick();
    idle();
    check_eq("drain_count", bus.count, 2);
    check_eq("drain_data", bus.deq_data, {32'hAF, 32'hAE});

    drive(1'b0, 1'b0, 2'b01, {32'h0, 32'h44}, 2'b01);
    tick();
    idle();
    check_eq("wrap_count", bus.count, 2);
    check_eq("wrap_data", bus.deq_data, {32'h44, 32'hAF});

    drive(1'b0, 1'b0, 2'b10, {32'h33, 32'hDEAD}, 2'b00);
    tick();
    idle();
    check_eq("lane1_count", bus.count, 3);
    check_eq("lane1_data", bus.deq_data, {32'h44, 32'hAF});

    drive(1'b0, 1'b0, 2'b00, 64'h0, 2'b10);
    tick();
    idle();
    check_eq("gap_count", bus.count, 3);
    check_eq("gap_data", bus.deq_data, {32'h44, 32'hAF});

    drive(1'b1, 1'b0, 2'b11, {32'h66, 32'h55}, 2'b11);
    #1;
    check_eq("stall_valid", bus.deq_valid, 0);
    check_eq("stall_data", bus.deq_data, 0);
    check_eq("stall_ready", bus.enq_ready, 1);
    tick();
    idle();
    check_eq("stall_count", bus.count, 5);

    drive(1'b0, 1'b0, 2'b00, 64'h0, 2'b11);
    tick();
    idle();
    check_eq("post_stall_count", bus.count, 3);
    check_eq("post_stall_data", bus.deq_data, {32'h55, 32'h33});

    // Flush overrides enqueue and dequeue.
    drive(1'b0, 1'b1, 2'b11, {32'h78, 32'h77}, 2'b11);
    tick();
    idle();
    check_eq("flush_count", bus.count, 0);
    check_eq("flush_valid", bus.deq_valid, 0);
    check_eq("flush_ready", bus.enq_ready, 1);
    check_eq("flush_ovf", bus.overflow_err, 0);
    check_eq("flush_data", bus.deq_data, 0);

    // Build count = 7, then assert reset between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11, {32'(8'hC1 + 2 * i), 32'(8'hC0 + 2 * i)}, 2'b00);
      tick();
    end
    drive(1'b0, 1'b0, 2'b01, {32'h0, 32'hC6}, 2'b00);
    tick();
    idle();
    check_eq("pre_rst_count", bus.count, 7);
    check_eq("pre_rst_data", bus.deq_data, {32'hC1, 32'hC0});
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_count", bus.count, 0);
    check_eq("async_rst_valid", bus.deq_valid, 0);
    check_eq("async_rst_data", bus.deq_data, 0);
    check_eq("async_rst_ready", bus.enq_ready, 1);
    reset = 1'b0;

    drive(1'b0, 1'b0, 2'b11, {32'hE1, 32'hE0}, 2'b00);
    tick();
    idle();
    check_eq("after_rst_count", bus.count, 2);
    check_eq("after_rst_data", bus.deq_data, {32'hE1, 32'hE0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
